// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and counter sizing for serial_adder
// Optional subtract mode is selected by SERIAL_ADDER_SUB_EN (see serial_adder.sv).
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle for serial_adder
// Carries sub_in only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_in;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub_in,
`endif
        output in_valid, a_in, b_in, cin_in, out_ready,
        input  in_ready, out_valid, sum_out, cout_out
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub_in,
`endif
        input  in_valid, a_in, b_in, cin_in, out_ready,
        output in_ready, out_valid, sum_out, cout_out
    );

endinterface

// File: rtl/serial_adder_fa_cell.sv
// rtl/serial_adder_fa_cell.sv - combinational 1-bit full adder cell
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic p;

    assign p     = a ^ b;
    assign sum   = p ^ cin;
    assign carry = (a & b) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder around one fa_cell, LSB first
// Define SERIAL_ADDER_SUB_EN to add sub_in (A-B via ~B and carry-in of 1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus,
    output logic           busy
);

    localparam int CW = cnt_width(WIDTH);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             cell_sum;
    logic             cell_carry;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = bus.sub_in ? ~bus.b_in : bus.b_in;
    assign c_load = bus.sub_in ? 1'b1      : bus.cin_in;
`else
    assign b_load = bus.b_in;
    assign c_load = bus.cin_in;
`endif

    fa_cell u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (carry),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    // Collected bits plus the one being produced this cycle, MSB-first fill.
    assign acc = {cell_sum, sum_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.a_in;
                        b_sh  <= b_load;
                        carry <= c_load;
                        cnt   <= CW'(WIDTH - 1);
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= acc[WIDTH-1:1];
                    carry  <= cell_carry;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        // Result registers only move here, so they hold across later operations.
                        sum_q  <= acc;
                        cout_q <= cell_carry;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign busy          = (state == S_RUN);
    assign bus.sum_out   = sum_q;
    assign bus.cout_out  = cout_q;

endmodule
